lc3_pipe_ctrl: RTL and testbench
================================

LC3_PIPE_CTRL -- requirements
Module: lc3_pipe_ctrl

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-002 clock  in  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state.
REQ-004 complete_instr  in  1  instruction memory access done; 0 = global freeze.
REQ-005 complete_data  in  1  data memory access done.
REQ-006 IMem_dout  in  16  instruction being fetched.
REQ-007 IR  in  16  instruction in decode (execute_in IR).
REQ-008 IR_Exec  in  16  instruction in execute.
REQ-009 psr  in  3  current NZP flags {N,Z,P}.
REQ-010 enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  stage enables.
REQ-011 br_taken  out  1  control transfer taken.
REQ-012 bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  out  1 each  forwarding selects for SR1/SR2.
REQ-013 mem_state  out  2  memory FSM: 0=READ, 1=INDIRECT, 2=WRITE, 3=IDLE.

Function
REQ-014 Start-up: enables fill one stage per cycle: updatePC+fetch at cycle 1 after reset release, decode at 2, execute at 3, writeback at 4.
REQ-015 complete_instr=0 freezes every register in the block; outputs hold their values.
REQ-016 Memory ops are decoded from IR_Exec[15:12] while enable_execute=1: LD 0010, LDR 0110, LDI 1010, ST 0011, STR 0111, STI 1011.
REQ-017 mem_state transitions from IDLE: LD/LDR -> READ; ST/STR -> WRITE; LDI/STI -> INDIRECT.
REQ-018 From INDIRECT, on complete_data=1: LDI -> READ, STI -> WRITE.
REQ-019 From READ or WRITE, on complete_data=1 -> IDLE.
REQ-020 No other mem_state transitions occur; complete_data is ignored in IDLE.
REQ-021 Memory stall: while mem_state != IDLE, updatePC, fetch, decode and execute are 0.
REQ-022 Writeback during a memory stall: enable_writeback is 1 only in the cycle READ exits to IDLE; 0 for stores.
REQ-023 Stall release: all enables return to 1 in the cycle after mem_state returns to IDLE.
REQ-024 Control hazard: when IMem_dout[15:12] is BR 0000 or JMP 1100 and enable_fetch=1, a 2-bit bubble counter loads 3.
REQ-025 Control stall: while the bubble counter is nonzero, enable_updatePC=enable_fetch=0 and the counter decrements each cycle.
REQ-026 Control bubble propagation: decode, execute and writeback see the bubble on successive cycles.
REQ-027 br_taken is combinational and only active when enable_execute=1: BR -> |(IR_Exec[11:9] & psr); JMP -> 1; otherwise 0.
REQ-028 bypass_alu_1 = IR_Exec is ADD/AND/NOT, IR is ADD/AND/NOT/LDR/STR/JMP, and IR[8:6]==IR_Exec[11:9].
REQ-029 bypass_alu_2 = IR_Exec is ADD/AND/NOT, IR is ADD/AND with IR[5]=0, and IR[2:0]==IR_Exec[11:9].
REQ-030 bypass_mem_1/2 use the same register comparisons against IR_Exec when it is LD/LDR/LDI.
REQ-031 Bypass outputs are 0 whenever enable_decode=0.
REQ-032 Simultaneous events: a memory stall has priority over a control bubble; the bubble counter holds while mem_state != IDLE.

Reset
REQ-033 Output reset values: all enables 0, br_taken 0, all bypass outputs 0, mem_state 3 (IDLE).
REQ-034 Internal reset values: bubble counter 0, start-up counter 0.
REQ-035 Reset asserted mid-operation (including INDIRECT) aborts immediately, then restarts per REQ-014.

Structure
REQ-036 Package lc3_ctrl_pkg_hdl holds the mem_state enum typedef and the 4-bit opcode constants, shared with the execute_in/writeback agents.
REQ-037 The memory state machine is sub-module lc3_mem_state_fsm (inputs: opcode, enable_execute, complete_data; output: mem_state).
REQ-038 The enable, bubble and bypass logic stays in lc3_pipe_ctrl.

Verification
REQ-039 Start-up: release reset with complete_instr=1 -> fetch=1 at cycle 1, decode at 2, execute at 3, writeback at 4.
REQ-040 LDI: IR_Exec=16'hA200, complete_data high 2 cycles later -> mem_state 3->1->0->3; writeback pulses once at READ exit.
REQ-041 Branch: IMem_dout=16'h0E05 (BRnzp) -> fetch low 3 cycles; br_taken=1 when in execute with psr=3'b010.
REQ-042 Forwarding: IR_Exec=16'h1261 (ADD R1,R1,#1), IR=16'h1442 (ADD R2,R1,R2) -> bypass_alu_1=1, bypass_alu_2=0.
REQ-043 Freeze: complete_instr=0 for 5 cycles mid-STR -> all outputs held; resumes unchanged.
REQ-044 Reset in INDIRECT: mem_state=3 and all enables=0 asynchronously.

Source files
------------

// File: rtl/lc3_ctrl_pkg_hdl.sv
// Shared LC-3 pipeline-control types: memory FSM state encoding and opcode constants.
// Also used by the execute_in and writeback agents.
package lc3_ctrl_pkg_hdl;

    typedef enum logic [1:0] {
        MEM_READ     = 2'd0,
        MEM_INDIRECT = 2'd1,
        MEM_WRITE    = 2'd2,
        MEM_IDLE     = 2'd3
    } mem_state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic is_load_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/lc3_mem_state_fsm.sv
// Data-memory access sequencer: walks loads/stores (direct or indirect) through
// READ/WRITE/INDIRECT and back to IDLE as data accesses complete.
module lc3_mem_state_fsm
    import lc3_ctrl_pkg_hdl::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       complete_instr,
    input  logic [3:0] opcode,
    input  logic       enable_execute,
    input  logic       complete_data,
    output mem_state_t mem_state
);

    mem_state_t state;
    mem_state_t state_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= MEM_IDLE;
        end else if (complete_instr) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MEM_IDLE: begin
                if (enable_execute) begin
                    case (opcode)
                        OP_LD, OP_LDR:  state_next = MEM_READ;
                        OP_ST, OP_STR:  state_next = MEM_WRITE;
                        OP_LDI, OP_STI: state_next = MEM_INDIRECT;
                        default:        state_next = MEM_IDLE;
                    endcase
                end
            end
            MEM_INDIRECT: begin
                // The pointer fetch is done; the opcode still in execute picks the final access.
                if (complete_data) begin
                    if (opcode == OP_LDI) begin
                        state_next = MEM_READ;
                    end else if (opcode == OP_STI) begin
                        state_next = MEM_WRITE;
                    end
                end
            end
            MEM_READ, MEM_WRITE: begin
                if (complete_data) begin
                    state_next = MEM_IDLE;
                end
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    assign mem_state = state;

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC-3 pipeline controller: stage enables with start-up fill, control-hazard bubbles,
// memory-access stalls, branch resolution and operand forwarding selects.
module lc3_pipe_ctrl
    import lc3_ctrl_pkg_hdl::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IMem_dout,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic [1:0]  mem_state
);

    logic [2:0] startup;
    logic [1:0] bubble;
    logic       decode_valid;
    logic       execute_valid;
    logic       writeback_valid;
    mem_state_t mstate;
    logic       mem_stall;
    logic       front_ok;
    logic       ctrl_hazard;

    logic [3:0] op_fetch;
    logic [3:0] op_dec;
    logic [3:0] op_exec;
    logic [2:0] exec_dr;
    logic       sr1_match;
    logic       sr2_match;
    logic       ir_uses_sr1;
    logic       ir_uses_sr2;
    logic       unused_bits;

    assign op_fetch = IMem_dout[15:12];
    assign op_dec   = IR[15:12];
    assign op_exec  = IR_Exec[15:12];
    assign exec_dr  = IR_Exec[11:9];
    assign unused_bits = ^{IMem_dout[11:0], IR[11:9], IR[4:3], IR_Exec[8:0]};

    lc3_mem_state_fsm u_mem_fsm (
        .clock          (clock),
        .reset          (reset),
        .complete_instr (complete_instr),
        .opcode         (op_exec),
        .enable_execute (enable_execute),
        .complete_data  (complete_data),
        .mem_state      (mstate)
    );

    assign mem_state   = mstate;
    assign mem_stall   = (mstate != MEM_IDLE);
    assign ctrl_hazard = (op_fetch == OP_BR) || (op_fetch == OP_JMP);

    assign front_ok         = (startup != 3'd0) && (bubble == 2'd0) && !mem_stall;
    assign enable_updatePC  = front_ok;
    assign enable_fetch     = front_ok;
    assign enable_decode    = decode_valid && !mem_stall;
    assign enable_execute   = execute_valid && !mem_stall;
    // Loads retire exactly once, as the READ access completes; stores never write back.
    assign enable_writeback = mem_stall ? ((mstate == MEM_READ) && complete_data)
                                        : writeback_valid;

    // Valid bits shift down the pipe so fetch gaps (start-up and bubbles) reach later stages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            startup         <= 3'd0;
            bubble          <= 2'd0;
            decode_valid    <= 1'b0;
            execute_valid   <= 1'b0;
            writeback_valid <= 1'b0;
        end else if (complete_instr) begin
            if (startup != 3'd4) begin
                startup <= startup + 3'd1;
            end
            if (!mem_stall) begin
                decode_valid    <= enable_fetch;
                execute_valid   <= decode_valid;
                writeback_valid <= execute_valid;
                if (bubble != 2'd0) begin
                    bubble <= bubble - 2'd1;
                end else if (enable_fetch && ctrl_hazard) begin
                    bubble <= 2'd3;
                end
            end
        end
    end

    always_comb begin
        br_taken = 1'b0;
        if (enable_execute) begin
            if (op_exec == OP_BR) begin
                br_taken = |(exec_dr & psr);
            end else if (op_exec == OP_JMP) begin
                br_taken = 1'b1;
            end
        end
    end

    assign ir_uses_sr1 = is_alu_op(op_dec) || (op_dec == OP_LDR) || (op_dec == OP_STR)
                         || (op_dec == OP_JMP);
    assign ir_uses_sr2 = ((op_dec == OP_ADD) || (op_dec == OP_AND)) && !IR[5];
    assign sr1_match   = enable_decode && ir_uses_sr1 && (IR[8:6] == exec_dr);
    assign sr2_match   = enable_decode && ir_uses_sr2 && (IR[2:0] == exec_dr);

    assign bypass_alu_1 = sr1_match && is_alu_op(op_exec);
    assign bypass_alu_2 = sr2_match && is_alu_op(op_exec);
    assign bypass_mem_1 = sr1_match && is_load_op(op_exec);
    assign bypass_mem_2 = sr2_match && is_load_op(op_exec);

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl: start-up, forwarding, branch bubbles, memory stalls,
// freeze and asynchronous reset, each step compared against hand-computed values.
module tb_lc3_pipe_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        complete_instr = 1'b1;
    logic        complete_data = 1'b0;
    logic [15:0] IMem_dout = 16'h1000;
    logic [15:0] IR = 16'hF025;
    logic [15:0] IR_Exec = 16'hF025;
    logic [2:0]  psr = 3'b010;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [1:0]  mem_state;

    int total = 0;
    int bad = 0;

    logic [4:0] en;
    logic [3:0] byp;
    assign en  = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
    assign byp = {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};

    lc3_pipe_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IMem_dout        (IMem_dout),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .psr              (psr),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .bypass_mem_2     (bypass_mem_2),
        .mem_state        (mem_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_en", 16'(en), 16'h00);
        chk("rst_br", 16'(br_taken), 16'h0);
        chk("rst_byp", 16'(byp), 16'h0);
        chk("rst_mem", 16'(mem_state), 16'h3);

        // Start-up fill
        reset = 1'b1;
        chk("start_c0", 16'(en), 16'b00000);
        step(); chk("start_c1", 16'(en), 16'b11000);
        step(); chk("start_c2", 16'(en), 16'b11100);
        step(); chk("start_c3", 16'(en), 16'b11110);
        step(); chk("start_c4", 16'(en), 16'b11111);

        // Forwarding selects
        IR_Exec = 16'h1261; IR = 16'h1442; #1;
        chk("fwd_add_sr1", 16'(byp), 16'b1000);
        IR = 16'h1441; #1;
        chk("fwd_add_both", 16'(byp), 16'b1100);
        IR = 16'h1462; #1;
        chk("fwd_imm", 16'(byp), 16'b1000);
        IR_Exec = 16'h2200; IR = 16'h1441; #1;
        chk("fwd_ld_both", 16'(byp), 16'b0011);
        IR_Exec = 16'hF025; IR = 16'hF025; #1;
        chk("fwd_none", 16'(byp), 16'b0000);

        // Branch bubble and resolution
        IMem_dout = 16'h0E05;
        step(); IMem_dout = 16'h1000; IR = 16'h0E05;
        chk("br_c1", 16'(en), 16'b00111);
        step(); IR = 16'hF025; IR_Exec = 16'h0E05; #1;
        chk("br_c2", 16'(en), 16'b00011);
        chk("br_taken", 16'(br_taken), 16'h1);
        IR_Exec = 16'h0805; #1;
        chk("br_not_taken", 16'(br_taken), 16'h0);
        IR_Exec = 16'h0E05;
        step();
        chk("br_c3", 16'(en), 16'b00001);
        chk("br_gated", 16'(br_taken), 16'h0);
        IR_Exec = 16'hF025;
        step(); chk("br_c4", 16'(en), 16'b11000);
        step(); chk("br_c5", 16'(en), 16'b11100);
        step(); chk("br_c6", 16'(en), 16'b11110);
        step(); chk("br_c7", 16'(en), 16'b11111);
        IR_Exec = 16'hC1C0; #1;
        chk("jmp_taken", 16'(br_taken), 16'h1);
        IR_Exec = 16'hF025; #1;

        // LDI: IDLE -> INDIRECT -> READ -> IDLE
        IR_Exec = 16'hA200;
        step();
        chk("ldi_ind_mem", 16'(mem_state), 16'h1);
        chk("ldi_ind_en", 16'(en), 16'b00000);
        step();
        chk("ldi_ind2_mem", 16'(mem_state), 16'h1);
        complete_data = 1'b1; #1;
        chk("ldi_ind2_en", 16'(en), 16'b00000);
        step();
        chk("ldi_rd_mem", 16'(mem_state), 16'h0);
        chk("ldi_rd_en", 16'(en), 16'b00001);
        step();
        IR_Exec = 16'hF025;
        chk("ldi_idle_mem", 16'(mem_state), 16'h3);
        chk("ldi_idle_en", 16'(en), 16'b11111);
        step();
        chk("idle_ignore_cd", 16'(mem_state), 16'h3);
        complete_data = 1'b0;

        // Freeze mid-STR
        IR_Exec = 16'h7240;
        step();
        chk("str_mem", 16'(mem_state), 16'h2);
        complete_instr = 1'b0; complete_data = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_mem", 16'(mem_state), 16'h2);
            chk("frz_en", 16'(en), 16'b00000);
        end
        complete_instr = 1'b1; complete_data = 1'b0;
        step();
        chk("frz_resume_mem", 16'(mem_state), 16'h2);
        complete_data = 1'b1;
        step();
        IR_Exec = 16'hF025; complete_data = 1'b0;
        chk("str_done_mem", 16'(mem_state), 16'h3);
        chk("str_done_en", 16'(en), 16'b11111);

        // Freeze during a control bubble
        IMem_dout = 16'h0E05;
        step(); IMem_dout = 16'h1000;
        chk("frzbr_c1", 16'(en), 16'b00111);
        complete_instr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frzbr_hold", 16'(en), 16'b00111);
        end
        complete_instr = 1'b1;
        step(); chk("frzbr_c2", 16'(en), 16'b00011);
        step(); chk("frzbr_c3", 16'(en), 16'b00001);
        step(); chk("frzbr_c4", 16'(en), 16'b11000);
        step(); step(); step();
        chk("frzbr_full", 16'(en), 16'b11111);

        // Memory stall takes priority; bubble counter holds
        IMem_dout = 16'h0E05; IR_Exec = 16'h2200;
        step(); IMem_dout = 16'h1000;
        chk("pri_mem", 16'(mem_state), 16'h0);
        chk("pri_en", 16'(en), 16'b00000);
        step();
        chk("pri_hold_mem", 16'(mem_state), 16'h0);
        complete_data = 1'b1; #1;
        chk("pri_wb", 16'(en), 16'b00001);
        step();
        IR_Exec = 16'hF025; complete_data = 1'b0;
        chk("pri_idle", 16'(mem_state), 16'h3);
        chk("pri_c1", 16'(en), 16'b00111);
        step(); chk("pri_c2", 16'(en), 16'b00011);
        step(); chk("pri_c3", 16'(en), 16'b00001);
        step(); chk("pri_c4", 16'(en), 16'b11000);
        step(); step(); step();
        chk("pri_full", 16'(en), 16'b11111);

        // STI: IDLE -> INDIRECT -> WRITE -> IDLE, no writeback
        IR_Exec = 16'hB200;
        step();
        chk("sti_ind", 16'(mem_state), 16'h1);
        complete_data = 1'b1;
        step();
        chk("sti_wr_mem", 16'(mem_state), 16'h2);
        chk("sti_wr_en", 16'(en), 16'b00000);
        step();
        IR_Exec = 16'hF025; complete_data = 1'b0;
        chk("sti_idle", 16'(mem_state), 16'h3);
        chk("sti_idle_en", 16'(en), 16'b11111);

        // Asynchronous reset while INDIRECT, then restart
        IR_Exec = 16'hA200;
        step();
        IR_Exec = 16'hF025;
        chk("ar_ind", 16'(mem_state), 16'h1);
        #2; reset = 1'b0; #1;
        chk("ar_mem", 16'(mem_state), 16'h3);
        chk("ar_en", 16'(en), 16'b00000);
        reset = 1'b1;
        step(); chk("ar_c1", 16'(en), 16'b11000);
        step(); chk("ar_c2", 16'(en), 16'b11100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
